// File: rtl/adc_frame_capture.sv
// adc_frame_capture: triggered multi-channel ADC frame capture, streamed to an SPI byte socket
// as flag, 16-bit length (LB first), data. Define ADC_FRAME_CSUM_EN to append a checksum byte.
module adc_frame_capture #(
    parameter int          CH_NUM     = 2,
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [7:0]  FLAG_BYTE  = 8'h5A
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    adc_valid,
    input  logic [8*CH_NUM-1:0]     adc_data,
    input  logic                    arm,
    input  logic                    cont,
    input  logic [1:0]              trig_mode,
    input  logic [7:0]              trig_level,
    input  logic                    trig_in,
    input  logic [DEPTH_LOG2:0]     frame_len,
    output logic [7:0]              txd_data,
    input  logic                    rxd_flag,
    output logic                    busy,
    output logic                    frame_done,
    output logic [7:0]              drop_cnt
);

    localparam int LW = DEPTH_LOG2 + 1;
    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [LW-1:0] MAX_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CW-1:0] LAST_CH = CW'(CH_NUM - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARMED    = 3'd1;
    localparam logic [2:0] S_CAPTURE  = 3'd2;
    localparam logic [2:0] S_HDR_FLAG = 3'd3;
    localparam logic [2:0] S_HDR_LB   = 3'd4;
    localparam logic [2:0] S_HDR_HB   = 3'd5;
    localparam logic [2:0] S_DATA     = 3'd6;
`ifdef ADC_FRAME_CSUM_EN
    localparam logic [2:0] S_CSUM     = 3'd7;
`endif

    logic [2:0]             state_q, state_d;
    logic [LW-1:0]          len_q, len_d;
    logic [1:0]             mode_q, mode_d;
    logic [7:0]             level_q, level_d;
    logic                   cont_q, cont_d;
    logic                   prev_valid_q, prev_valid_d;
    logic [7:0]             prev_ch0_q, prev_ch0_d;
    logic                   trig_in_q, trig_in_d;
    logic [LW-1:0]          wr_addr_q, wr_addr_d;
    logic [LW-1:0]          point_q, point_d;
    logic [CW-1:0]          ch_q, ch_d;
    logic [DEPTH_LOG2-1:0]  rd_addr_q, rd_addr_d;
    logic [8*CH_NUM-1:0]    cur_word_q, cur_word_d;
    logic [7:0]             drop_q, drop_d;
    logic                   done_q, done_d;
`ifdef ADC_FRAME_CSUM_EN
    logic [7:0]             csum_q, csum_d;
`endif

    logic [8*CH_NUM-1:0]    mem [2**DEPTH_LOG2];
    logic [8*CH_NUM-1:0]    ram_rd_q;
    logic                   wr_en;
    logic                   frame_end;
    logic                   trig_hit;
    logic                   last_byte;
    logic [7:0]             ch0;
    logic [7:0]             data_byte;
    logic [15:0]            len16;

    assign ch0       = adc_data[7:0];
    assign len16     = 16'(len_q * CH_NUM);
    assign data_byte = cur_word_q[{ch_q, 3'b000} +: 8];
    assign last_byte = (ch_q == LAST_CH) && (point_q == len_q - 1'b1);

    always_comb begin
        trig_hit = 1'b0;
        if (prev_valid_q) begin
            case (mode_q)
                2'd1:    trig_hit = (prev_ch0_q < level_q) && (ch0 >= level_q);
                2'd2:    trig_hit = (prev_ch0_q >= level_q) && (ch0 < level_q);
                default: trig_hit = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        mode_d       = mode_q;
        level_d      = level_q;
        cont_d       = cont_q;
        prev_valid_d = prev_valid_q;
        prev_ch0_d   = prev_ch0_q;
        trig_in_d    = trig_in;
        wr_addr_d    = wr_addr_q;
        point_d      = point_q;
        ch_d         = ch_q;
        rd_addr_d    = rd_addr_q;
        cur_word_d   = cur_word_q;
        drop_d       = drop_q;
        done_d       = 1'b0;
        wr_en        = 1'b0;
        frame_end    = 1'b0;
`ifdef ADC_FRAME_CSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            S_IDLE: if (arm) begin
                state_d      = S_ARMED;
                len_d        = (frame_len == '0 || frame_len > MAX_LEN) ? MAX_LEN : frame_len;
                mode_d       = trig_mode;
                level_d      = trig_level;
                cont_d       = cont;
                drop_d       = '0;
                prev_valid_d = 1'b0;
                wr_addr_d    = '0;
            end
            S_ARMED: begin
                case (mode_q)
                    2'd0: state_d = S_CAPTURE;
                    2'd3: if (trig_in && !trig_in_q) state_d = S_CAPTURE;
                    default: if (adc_valid) begin
                        prev_valid_d = 1'b1;
                        prev_ch0_d   = ch0;
                        // The triggering sample itself becomes point 0.
                        if (trig_hit) begin
                            wr_en     = 1'b1;
                            wr_addr_d = LW'(1);
                            state_d   = (len_q == LW'(1)) ? S_HDR_FLAG : S_CAPTURE;
                        end
                    end
                endcase
            end
            S_CAPTURE: if (adc_valid) begin
                wr_en     = 1'b1;
                wr_addr_d = wr_addr_q + 1'b1;
                if (wr_addr_q == len_q - 1'b1) state_d = S_HDR_FLAG;
            end
            S_HDR_FLAG: begin
                // Point 0 is read from the RAM while the header bytes are being sent.
                rd_addr_d = '0;
                point_d   = '0;
                ch_d      = '0;
`ifdef ADC_FRAME_CSUM_EN
                csum_d    = '0;
`endif
                if (rxd_flag) state_d = S_HDR_LB;
            end
            S_HDR_LB: if (rxd_flag) begin
                state_d = S_HDR_HB;
`ifdef ADC_FRAME_CSUM_EN
                csum_d  = csum_q + len16[7:0];
`endif
            end
            S_HDR_HB: if (rxd_flag) begin
                state_d    = S_DATA;
                cur_word_d = ram_rd_q;
                rd_addr_d  = rd_addr_q + 1'b1;
`ifdef ADC_FRAME_CSUM_EN
                csum_d     = csum_q + len16[15:8];
`endif
            end
            S_DATA: if (rxd_flag) begin
`ifdef ADC_FRAME_CSUM_EN
                csum_d = csum_q + data_byte;
`endif
                if (ch_q == LAST_CH) begin
                    ch_d       = '0;
                    point_d    = point_q + 1'b1;
                    cur_word_d = ram_rd_q;
                    rd_addr_d  = rd_addr_q + 1'b1;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
                if (last_byte) begin
`ifdef ADC_FRAME_CSUM_EN
                    state_d = S_CSUM;
`else
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef ADC_FRAME_CSUM_EN
            S_CSUM: if (rxd_flag) frame_end = 1'b1;
`endif
            default: state_d = S_IDLE;
        endcase

        if (frame_end) begin
            state_d      = cont_q ? S_ARMED : S_IDLE;
            done_d       = 1'b1;
            prev_valid_d = 1'b0;
            wr_addr_d    = '0;
        end

        if (adc_valid && state_q >= S_HDR_FLAG && drop_q != '1) drop_d = drop_q + 1'b1;
    end

    always_comb begin
        case (state_q)
            S_HDR_FLAG: txd_data = FLAG_BYTE;
            S_HDR_LB:   txd_data = len16[7:0];
            S_HDR_HB:   txd_data = len16[15:8];
            S_DATA:     txd_data = data_byte;
`ifdef ADC_FRAME_CSUM_EN
            S_CSUM:     txd_data = csum_q;
`endif
            default:    txd_data = '0;
        endcase
    end

    assign busy       = (state_q != S_IDLE) || done_q;
    assign frame_done = done_q;
    assign drop_cnt   = drop_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            mode_q       <= '0;
            level_q      <= '0;
            cont_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_ch0_q   <= '0;
            trig_in_q    <= 1'b0;
            wr_addr_q    <= '0;
            point_q      <= '0;
            ch_q         <= '0;
            rd_addr_q    <= '0;
            cur_word_q   <= '0;
            drop_q       <= '0;
            done_q       <= 1'b0;
`ifdef ADC_FRAME_CSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            mode_q       <= mode_d;
            level_q      <= level_d;
            cont_q       <= cont_d;
            prev_valid_q <= prev_valid_d;
            prev_ch0_q   <= prev_ch0_d;
            trig_in_q    <= trig_in_d;
            wr_addr_q    <= wr_addr_d;
            point_q      <= point_d;
            ch_q         <= ch_d;
            rd_addr_q    <= rd_addr_d;
            cur_word_q   <= cur_word_d;
            drop_q       <= drop_d;
            done_q       <= done_d;
`ifdef ADC_FRAME_CSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr_q[DEPTH_LOG2-1:0]] <= adc_data;
        ram_rd_q <= mem[rd_addr_q];
    end

endmodule

// File: tb/tb_adc_frame_capture.sv
// Self-checking bench for adc_frame_capture: table-driven frames, hand-written corner sequences
// and randomized frames, all compared against a queue-based frame model.
`timescale 1ns/1ps
module tb_adc_frame_capture;

    localparam int CH   = 2;
    localparam int DL   = 4;
    localparam int MAXL = 1 << DL;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             adc_valid = 1'b0;
    logic [8*CH-1:0]  adc_data = '0;
    logic             arm = 1'b0;
    logic             cont = 1'b0;
    logic [1:0]       trig_mode = '0;
    logic [7:0]       trig_level = '0;
    logic             trig_in = 1'b0;
    logic [DL:0]      frame_len = '0;
    logic [7:0]       txd_data;
    logic             rxd_flag = 1'b0;
    logic             busy;
    logic             frame_done;
    logic [7:0]       drop_cnt;

    adc_frame_capture #(.CH_NUM(CH), .DEPTH_LOG2(DL), .FLAG_BYTE(8'h5A)) dut (
        .clk(clk), .resetn(resetn), .adc_valid(adc_valid), .adc_data(adc_data),
        .arm(arm), .cont(cont), .trig_mode(trig_mode), .trig_level(trig_level),
        .trig_in(trig_in), .frame_len(frame_len), .txd_data(txd_data),
        .rxd_flag(rxd_flag), .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    always @(posedge clk) if (frame_done === 1'b1) done_cnt++;

    // Frame model: samples offered to the DUT and the byte stream the rules imply.
    logic [15:0] sent[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          rd_idx;
    int          m_mode, m_level, m_len;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  level;
        logic [4:0]  flen;
        int          npre;
        logic [31:0] pre;
        logic [15:0] exp_len;
        logic [7:0]  exp_first;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int trig_start();
        if (m_mode == 0 || m_mode == 3) return 0;
        for (int i = 1; i < sent.size(); i++) begin
            automatic int p = int'(sent[i-1][7:0]);
            automatic int c = int'(sent[i][7:0]);
            if (m_mode == 1 && p < m_level && c >= m_level) return i;
            if (m_mode == 2 && p >= m_level && c < m_level) return i;
        end
        return -1;
    endfunction

    function automatic bit model_done();
        automatic int s = trig_start();
        return (s >= 0) && (sent.size() >= s + m_len);
    endfunction

    task automatic build_expected();
        automatic int s = trig_start();
        automatic int len = m_len * CH;
        exp_q.delete();
        got_q.delete();
        rd_idx = 0;
        exp_q.push_back(8'h5A);
        exp_q.push_back(len[7:0]);
        exp_q.push_back(len[15:8]);
        for (int p = 0; p < m_len; p++)
            for (int c = 0; c < CH; c++)
                exp_q.push_back(sent[s+p][8*c +: 8]);
`ifdef ADC_FRAME_CSUM_EN
        begin
            automatic int sum = 0;
            for (int i = 1; i < exp_q.size(); i++) sum += int'(exp_q[i]);
            exp_q.push_back(sum[7:0]);
        end
`endif
    endtask

    task automatic consume(input int n);
        for (int k = 0; k < n && rd_idx < exp_q.size(); k++) begin
            chk("txd_byte", txd_data, exp_q[rd_idx]);
            got_q.push_back(txd_data);
            rxd_flag = 1'b1;
            tick();
            rxd_flag = 1'b0;
            rd_idx++;
            chk("frame_done_pulse", frame_done, (rd_idx == exp_q.size()));
            tick();
            tick();
        end
    endtask

    task automatic send_sample(input logic [15:0] w, input int gap);
        adc_data  = w;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        repeat (gap) tick();
        sent.push_back(w);
    endtask

    task automatic send_drop(input int n);
        adc_valid = 1'b1;
        repeat (n) tick();
        adc_valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic arm_frame(input int mode, input int level, input int flen, input bit c);
        trig_mode  = 2'(mode);
        trig_level = 8'(level);
        frame_len  = (DL+1)'(flen);
        cont       = c;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        chk("busy_after_arm", busy, 1);
        m_mode  = mode;
        m_level = level;
        m_len   = (flen == 0 || flen > MAXL) ? MAXL : flen;
        sent.delete();
        tick();
        tick();
        if (mode == 3) begin
            trig_in = 1'b1;
            tick();
            trig_in = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic feed(input int npre, input logic [31:0] pre, input bit ramp, output bit ok);
        automatic int n = 0;
        while (!model_done() && n < 300) begin
            logic [15:0] w;
            logic [7:0]  c0;
            if (n < npre) begin
                c0 = pre[31-8*n -: 8];
                w  = {c0 ^ 8'hD0, c0};
            end else if (ramp) begin
                c0 = 8'h10 + 8'(2*(n-npre));
                w  = {c0 + 8'h01, c0};
            end else begin
                w = 16'($urandom);
            end
            send_sample(w, ramp ? 1 : $urandom_range(1, 3));
            n++;
        end
        ok = model_done();
        tick();
        chk("hdr_flag", txd_data, ok ? 8'h5A : 8'h00);
    endtask

    task automatic run_frame(input int mode, input int level, input int flen, input bit c,
                             input int npre, input logic [31:0] pre, input bit ramp);
        bit ok;
        int d0;
        arm_frame(mode, level, flen, c);
        feed(npre, pre, ramp, ok);
        if (!ok) begin
            do_reset();
            return;
        end
        build_expected();
        d0 = done_cnt;
        consume(exp_q.size());
        chk("done_count", done_cnt - d0, 1);
        chk("busy_end", busy, c);
    endtask

    initial begin
        bit ok;
        tbl[0] = '{2'd0, 8'h00, 5'd4,  0, 32'h0,          16'h0008, 8'h10};
        tbl[1] = '{2'd1, 8'h80, 5'd2,  4, 32'h90709095,   16'h0004, 8'h90};
        tbl[2] = '{2'd0, 8'h00, 5'd0,  0, 32'h0,          16'h0020, 8'h10};
        tbl[3] = '{2'd2, 8'h40, 5'd1,  4, 32'h3050403F,   16'h0002, 8'h3F};
        tbl[4] = '{2'd3, 8'h00, 5'd3,  0, 32'h0,          16'h0006, 8'h10};
        tbl[5] = '{2'd0, 8'h00, 5'd17, 0, 32'h0,          16'h0020, 8'h10};
        tbl[6] = '{2'd1, 8'h80, 5'd1,  2, 32'h7F800000,   16'h0002, 8'h80};
        tbl[7] = '{2'd0, 8'h00, 5'd1,  1, 32'hF0000000,   16'h0002, 8'hF0};

        tick();
        tick();
        chk("rst_txd", txd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_drop", drop_cnt, 0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].mode, tbl[i].level, tbl[i].flen, 1'b0, tbl[i].npre, tbl[i].pre, 1'b1);
            if (got_q.size() > 3) begin
                chk("tbl_len", {got_q[2], got_q[1]}, tbl[i].exp_len);
                chk("tbl_first", got_q[3], tbl[i].exp_first);
            end
        end
`ifdef ADC_FRAME_CSUM_EN
        chk("csum_byte", got_q[got_q.size()-1], 8'h12);
`endif

        // Drops while streaming data, saturation, and clear on the next arm.
        arm_frame(0, 0, 2, 1'b0);
        feed(0, 32'h0, 1'b1, ok);
        build_expected();
        consume(3);
        send_drop(5);
        chk("drop_5", drop_cnt, 5);
        send_drop(295);
        chk("drop_sat", drop_cnt, 255);
        consume(exp_q.size() - 3);
        tick();
        chk("busy_idle", busy, 0);
        arm_frame(0, 0, 1, 1'b0);
        chk("drop_clear", drop_cnt, 0);
        feed(0, 32'h0, 1'b1, ok);
        build_expected();
        consume(exp_q.size());

        // Continuous mode, then reset in the middle of the second frame's data.
        arm_frame(0, 0, 1, 1'b1);
        feed(1, 32'h5B000000, 1'b0, ok);
        build_expected();
        consume(exp_q.size());
        chk("busy_cont", busy, 1);
        sent.delete();
        tick();
        feed(1, 32'hC3000000, 1'b0, ok);
        build_expected();
        consume(4);
        resetn = 1'b0;
        #1;
        chk("rst_mid_txd", txd_data, 0);
        chk("rst_mid_busy", busy, 0);
        tick();
        resetn = 1'b1;
        tick();
        run_frame(0, 0, 3, 1'b0, 0, 32'h0, 1'b1);

        for (int r = 0; r < 10; r++)
            run_frame($urandom_range(0, 3), $urandom_range(32, 224), $urandom_range(0, 20),
                      1'b0, 0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
